serial_to_parallel: RTL

//  Receive-side counterpart of the team's MSB-first serial shifter.
//  - Deserialises a 1-bit MSB-first stream into WIDTH-bit words.
//  - Frames are delimited by a start strobe.
//  - Presents completed words on a registered valid/ready output port.
//  - Flags words lost to backpressure.

---
 rtl/s2p_pkg.sv | 11 +
 rtl/s2p_out_reg.sv | 59 +++++
 rtl/serial_to_parallel.sv | 101 ++++++++++
 3 files changed

// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
package s2p_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } s2p_state_t;

  localparam int OVR_CNT_W = 8;

endpackage

// File: rtl/s2p_out_reg.sv
// Output holding register for serial_to_parallel: valid/ready handshake,
// drop-on-backpressure and the one-cycle overrun pulse.
// Optional macro S2P_OVERRUN_CNT_EN adds a saturating overrun event counter.
module s2p_out_reg
  import s2p_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun
`ifdef S2P_OVERRUN_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0] ovr_count
`endif
);

  // A new word may enter only if the slot is empty or is being emptied now;
  // otherwise the incoming word is discarded and the held one is kept.
  logic accept;
  logic drop;

  assign accept = !out_valid || out_ready;
  assign drop   = load_en && !accept;

  // Holding register, valid flag and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= drop;
      if (load_en && accept) begin
        out_data  <= load_data;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef S2P_OVERRUN_CNT_EN
  // Saturating count of dropped words; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_count <= '0;
    end else if (drop && (ovr_count != {OVR_CNT_W{1'b1}})) begin
      ovr_count <= ovr_count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: deserialises an MSB-first bit stream into WIDTH-bit
// words framed by a start strobe, and hands them to a valid/ready port.
// Optional macro S2P_OVERRUN_CNT_EN adds the ovr_count output.
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
`ifdef S2P_OVERRUN_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0] ovr_count
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  // The shift register only needs the WIDTH-1 bits received before the
  // final one; the final bit goes straight into the completed word.
  localparam int SR_W  = WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  s2p_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic             word_done;
  logic [WIDTH-1:0] word;

  assign word = {sr_q, serial_in};
  assign busy = (state_q != S_IDLE);

  // State, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  // Next-state logic: a start strobe always begins a fresh frame, even on
  // what would have been the final bit of the current one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    word_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = SR_W'(serial_in);
          cnt_d   = CNT_ONE;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (start) begin
          sr_d  = SR_W'(serial_in);
          cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          word_done = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          sr_d  = (sr_q << 1) | SR_W'(serial_in);
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  s2p_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load_en  (word_done),
    .load_data(word),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .overrun  (overrun)
`ifdef S2P_OVERRUN_CNT_EN
    ,
    .ovr_count(ovr_count)
`endif
  );

endmodule
